// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared state/class types and default widths for the coin acceptor
// Revision : 1.0
// ============================================================================
package vend_pkg;

   localparam int c_SYNC_STAGES = 2;
   localparam int c_DEB_CYCLES  = 4;
   localparam int c_NICKEL_MIN  = 8;
   localparam int c_NICKEL_MAX  = 15;
   localparam int c_DIME_MIN    = 20;
   localparam int c_DIME_MAX    = 31;
   localparam int c_TIMEOUT     = 48;
   localparam int c_GAP_CYCLES  = 8;
   localparam int c_CNT_W       = 6;

   typedef enum logic [1:0] {IDLE, MEASURE, GAP, FAULT} coin_state_t;
   typedef enum logic [1:0] {NONE, NICKEL, DIME, REJECT} coin_class_t;

   // Dime window is tested first so overlapping windows resolve to the larger coin.
   function automatic coin_class_t classify(input int   w,
                                            input logic bad,
                                            input int   nmin,
                                            input int   nmax,
                                            input int   dmin,
                                            input int   dmax);
      coin_class_t cls;
      if (bad)                           cls = REJECT;
      else if (w >= dmin && w <= dmax)   cls = DIME;
      else if (w >= nmin && w <= nmax)   cls = NICKEL;
      else                               cls = REJECT;
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
// coin_debounce : synchroniser chain plus stability counter on the coin sensor
// Revision      : 1.0
// ============================================================================
module coin_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_sense_i,
   output logic db_o
);

   localparam int c_DCW = $clog2(DEB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [c_DCW-1:0]       stab_q, stab_d;
   logic                   db_q, db_d;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         stab_q <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= SYNC_STAGES'({sync_q, coin_sense_i});
         stab_q <= stab_d;
         db_q   <= db_d;
      end
   end

   // The counter tracks consecutive mismatch cycles; any agreement clears it.
   always_comb begin
      stab_d = '0;
      db_d   = db_q;
      if (sync != db_q) begin
         if (stab_q == c_DCW'(DEB_CYCLES - 1)) begin
            db_d = sync;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
   end

   assign db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// coin_acceptor : pulse-width coin classifier emitting n / d / reject strobes
// Revision      : 1.0
// ============================================================================
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int SYNC_STAGES = c_SYNC_STAGES,
   parameter int DEB_CYCLES  = c_DEB_CYCLES,
   parameter int NICKEL_MIN  = c_NICKEL_MIN,
   parameter int NICKEL_MAX  = c_NICKEL_MAX,
   parameter int DIME_MIN    = c_DIME_MIN,
   parameter int DIME_MAX    = c_DIME_MAX,
   parameter int TIMEOUT     = c_TIMEOUT,
   parameter int GAP_CYCLES  = c_GAP_CYCLES,
   parameter int CNT_W       = c_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_sense,
   input  logic inhibit,
   output logic n,
   output logic d,
   output logic reject,
   output logic fault,
   output logic busy
);

   localparam int               c_GW        = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_TMO   = CNT_W'(TIMEOUT);
   localparam logic [c_GW-1:0]  c_GAP_LOAD  = c_GW'(GAP_CYCLES);
   localparam logic [c_GW-1:0]  c_GAP_ONE   = c_GW'(1);

   logic db;

   coin_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .coin_sense_i (coin_sense),
      .db_o         (db)
   );

   coin_state_t      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [c_GW-1:0]  gap_q, gap_d;
   logic             bad_q, bad_d;
   logic             n_q, n_d, d_q, d_d, reject_q, reject_d;
   logic             fault_q, fault_d, busy_q, busy_d;
   coin_class_t      cls;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         gap_q    <= '0;
         bad_q    <= 1'b0;
         n_q      <= 1'b0;
         d_q      <= 1'b0;
         reject_q <= 1'b0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         bad_q    <= bad_d;
         n_q      <= n_d;
         d_q      <= d_d;
         reject_q <= reject_d;
         fault_q  <= fault_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      gap_d    = gap_q;
      bad_d    = bad_q;
      n_d      = 1'b0;
      d_d      = 1'b0;
      reject_d = 1'b0;
      fault_d  = fault_q;
      cls      = NONE;

      case (state_q)
         IDLE: begin
            if (db) begin
               state_d = MEASURE;
               count_d = c_CNT_ONE;
               bad_d   = inhibit;
            end
         end
         MEASURE: begin
            if (db) begin
               if (count_q != '1) count_d = count_q + 1'b1;
               if (count_d >= c_CNT_TMO) begin
                  state_d  = FAULT;
                  reject_d = 1'b1;
                  fault_d  = 1'b1;
               end
            end else begin
               cls      = classify(32'(count_q), bad_q, NICKEL_MIN, NICKEL_MAX,
                                   DIME_MIN, DIME_MAX);
               n_d      = (cls == NICKEL);
               d_d      = (cls == DIME);
               reject_d = (cls == REJECT);
               state_d  = GAP;
               gap_d    = c_GAP_LOAD;
            end
         end
         GAP: begin
            // A coin arriving inside the hold-off is measured but always refused.
            if (db) begin
               state_d = MEASURE;
               count_d = c_CNT_ONE;
               bad_d   = 1'b1;
            end else if (gap_q <= c_GAP_ONE) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         FAULT: begin
            if (!db) begin
               fault_d = 1'b0;
               state_d = GAP;
               gap_d   = c_GAP_LOAD;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign n      = n_q;
   assign d      = d_q;
   assign reject = reject_q;
   assign fault  = fault_q;
   assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// tb_coin_acceptor : randomized scoreboard bench for coin_acceptor
// Revision         : 1.0
// ============================================================================
module tb_coin_acceptor;

   // Response codes used by the reference model.
   localparam int K_NICKEL = 1;
   localparam int K_DIME   = 2;
   localparam int K_REJECT = 3;
   localparam int K_STUCK  = 4;   // reject together with fault

   logic clk = 1'b0;
   logic reset, coin_sense, inhibit;
   logic n, d, reject, fault, busy;

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk        (clk),
      .reset      (reset),
      .coin_sense (coin_sense),
      .inhibit    (inhibit),
      .n          (n),
      .d          (d),
      .reject     (reject),
      .fault      (fault),
      .busy       (busy)
   );

   int exp_q[$];
   int checks = 0;
   int errors = 0;
   int since_fall = 1000;   // raw low cycles since the last real coin ended
   int mon_got, mon_exp;

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Width rules applied directly to the raw high time (debounce delays both edges equally).
   function automatic int model(input int h, input bit bad);
      if (h >= 48)               return K_STUCK;
      if (bad)                   return K_REJECT;
      if (h >= 20 && h <= 31)    return K_DIME;
      if (h >= 8  && h <= 15)    return K_NICKEL;
      return K_REJECT;
   endfunction

   // mode 0: inhibit low, 1: inhibit high across the coin, 2: inhibit rises late in the coin
   task automatic coin(input int h, input int low, input int mode);
      bit bad;
      bad = (mode == 1) || (since_fall <= 8);
      if (h >= 4) exp_q.push_back(model(h, bad));
      coin_sense = 1'b1;
      inhibit    = (mode == 1);
      for (int i = 0; i < h; i++) begin
         if (mode == 2 && i == h - 1) inhibit = 1'b1;
         tick(1);
      end
      coin_sense = 1'b0;
      tick(low);
      if (mode == 2) inhibit = 1'b0;
      if (h >= 4) since_fall = low;
      else        since_fall = since_fall + h + low;
   endtask

   // Monitor: pop one expectation per strobe cycle.
   always @(negedge clk) begin
      if (!reset && (n || d || reject)) begin
         check("strobe_onehot", $countones({n, d, reject}), 1);
         mon_got = n ? K_NICKEL : (d ? K_DIME : (fault ? K_STUCK : K_REJECT));
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", mon_got, 0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("strobe_class", mon_got, mon_exp);
         end
      end
   end

   initial begin
      int lat;
      int seen;
      int hits;
      int widths[8];
      widths = '{8, 15, 20, 31, 7, 16, 19, 32};

      reset = 1'b1; coin_sense = 1'b0; inhibit = 1'b0;
      tick(3);
      check("reset_outputs", int'({n, d, reject, fault, busy}), 0);
      reset = 1'b0;
      tick(5);

      // Reset in the middle of a measurement must cancel the coin.
      coin_sense = 1'b1;
      tick(16);
      check("busy_measuring", int'(busy), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      exp_q.delete();
      check("async_reset_outputs", int'({n, d, reject, fault, busy}), 0);
      coin_sense = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(30);
      check("busy_after_reset", int'(busy), 0);
      since_fall = 1000;

      // Strobe latency: raw fall -> sync + debounce -> one registered cycle.
      exp_q.push_back(K_NICKEL);
      coin_sense = 1'b1;
      tick(10);
      coin_sense = 1'b0;
      lat = 0; seen = 0;
      for (int i = 1; i <= 40 && seen == 0; i++) begin
         tick(1);
         if (n || d || reject) begin lat = i; seen = 1; end
      end
      check("strobe_latency", lat, 7);
      tick(30);
      since_fall = 1000;

      coin(10, 30, 0);
      coin(25, 30, 0);
      foreach (widths[i]) coin(widths[i], 30, 0);
      coin(47, 30, 0);
      coin(48, 30, 0);

      // Short glitches never reach the classifier.
      hits = 0;
      for (int g = 1; g <= 3; g++) begin
         coin_sense = 1'b1;
         tick(g);
         coin_sense = 1'b0;
         for (int i = 0; i < 10; i++) begin
            tick(1);
            if (busy) hits++;
         end
      end
      check("glitch_busy", hits, 0);
      since_fall = 1000;

      coin(10, 30, 1);
      coin(10, 30, 2);
      coin(10, 4, 0);
      coin(10, 8, 0);
      coin(10, 9, 0);
      coin(10, 30, 0);

      // Stuck sensor: fault during the hold, cleared on release, then a full hold-off.
      exp_q.push_back(K_STUCK);
      coin_sense = 1'b1;
      tick(60);
      check("stuck_fault", int'(fault), 1);
      coin_sense = 1'b0;
      tick(10);
      check("fault_cleared", int'(fault), 0);
      check("gap_busy", int'(busy), 1);
      tick(4);
      check("gap_last_cycle", int'(busy), 1);
      tick(1);
      check("idle_after_gap", int'(busy), 0);
      tick(20);
      since_fall = 1000;

      for (int k = 0; k < 150; k++) begin
         int r, h;
         r = $urandom_range(0, 9);
         if (r == 0)      h = $urandom_range(1, 3);
         else if (r == 1) h = $urandom_range(48, 60);
         else             h = $urandom_range(4, 40);
         coin(h, $urandom_range(4, 20), ($urandom_range(0, 4) == 0) ? 1 : 0);
      end

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
      check("queue_drained", exp_q.size(), 0);
      tick(20);
      check("final_idle", int'({busy, fault}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
